// File: rtl/counter_pkg.sv
// Shared types and constants for the tick-driven counter family.
package counter_pkg;

    localparam int unsigned CLK_HZ = 100_000_000;

    typedef enum logic [1:0] {
        M_UPWRAP = 2'd0,
        M_DNWRAP = 2'd1,
        M_UPSAT  = 2'd2,
        M_BOUNCE = 2'd3
    } cnt_mode_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    // Tick rate in Hz produced by a divider of the given ratio.
    function automatic int unsigned tick_hz(input int unsigned div);
        return CLK_HZ / div;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running clock divider producing a registered one-cycle tick every DIV clocks.
// clr restarts the period so the next tick arrives a full DIV clocks later.
module tick_gen #(
    parameter int unsigned DIV = 50_000_000
) (
    input  logic clk_100MHz,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          tick_q, tick_d;
    logic          wrap_c;

    assign wrap_c = (div_cnt_q == DW'(DIV - 1));

    always_comb begin
        div_cnt_d = div_cnt_q + DW'(1);
        tick_d    = wrap_c;
        if (clr) begin
            div_cnt_d = '0;
            tick_d    = 1'b0;
        end else if (wrap_c) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/counter_tick_multi.sv
// Tick-driven multi-mode counter (up-wrap, down-wrap, up-saturate, bounce) with terminal-count pulse.
// Define COUNTER_LOAD_EN to add the synchronous parallel load ports (load, load_val).
module counter_tick_multi
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned DIV     = 50_000_000,
    parameter int unsigned RST_VAL = 1
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic [1:0]       mode,
`ifdef COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX     = '1;
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    dir_t             dir_q, dir_d;
    cnt_mode_t        mode_c;
    logic             adv_c;
    logic             load_c;
    logic [WIDTH-1:0] load_val_c;
    logic             tick_c;

`ifdef COUNTER_LOAD_EN
    assign load_c     = load;
    assign load_val_c = load_val;
`else
    assign load_c     = 1'b0;
    assign load_val_c = '0;
`endif

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .clr        (load_c),
        .tick       (tick_c)
    );

    assign mode_c = cnt_mode_t'(mode);
    assign adv_c  = tick_c && cnt_en;

    // Direction state register
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            dir_q <= DIR_UP;
        end else begin
            dir_q <= dir_d;
        end
    end

    // Direction next-state: leaving bounce mode always re-arms upward
    always_comb begin
        dir_d = dir_q;
        if (mode_c != M_BOUNCE) begin
            dir_d = DIR_UP;
        end else if (!load_c && adv_c) begin
            case (dir_q)
                DIR_UP:  if (cnt_q == MAX) dir_d = DIR_DN;
                DIR_DN:  if (cnt_q == '0)  dir_d = DIR_UP;
                default: dir_d = DIR_UP;
            endcase
        end
    end

    // Count and terminal-count next values; load outranks an advance
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (load_c) begin
            cnt_d = load_val_c;
        end else if (adv_c) begin
            case (mode_c)
                M_UPWRAP: begin
                    cnt_d = cnt_q + WIDTH'(1);
                    tc_d  = (cnt_q == MAX);
                end
                M_DNWRAP: begin
                    cnt_d = cnt_q - WIDTH'(1);
                    tc_d  = (cnt_q == '0);
                end
                M_UPSAT: begin
                    if (cnt_q != MAX) begin
                        cnt_d = cnt_q + WIDTH'(1);
                        tc_d  = (cnt_q == MAX - WIDTH'(1));
                    end
                end
                M_BOUNCE: begin
                    if (dir_q == DIR_UP) begin
                        if (cnt_q == MAX) begin
                            cnt_d = MAX - WIDTH'(1);
                            tc_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end
                    end else begin
                        if (cnt_q == '0) begin
                            cnt_d = WIDTH'(1);
                            tc_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - WIDTH'(1);
                        end
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            cnt_q <= RST_CNT;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign cnt  = cnt_q;
    assign tick = tick_c;
    assign tc   = tc_q;

endmodule
